// File: rtl/adsr.sv
// ADSR envelope generator: fixed-point level accumulator driven by per-clock
// attack/decay/release rates, with a sustain target and an amplitude output.
`default_nettype none

package mypackage;
  localparam int AMPLITUDE_BITS = 16;
  typedef logic [AMPLITUDE_BITS-1:0] amplitude;
endpackage

module adsr #(
  parameter int TOTAL_BITS      = 48,
  parameter int FRACTIONAL_BITS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [TOTAL_BITS-1:0] attack_time,
  input  logic signed [TOTAL_BITS-1:0] decay_time,
  input  mypackage::amplitude          sustain,
  input  logic signed [TOTAL_BITS-1:0] release_time,
  input  logic                         gate,
  output mypackage::amplitude          out,
  output logic                         active
);

  localparam int AB = mypackage::AMPLITUDE_BITS;
  localparam int GW = TOTAL_BITS + 1;

  localparam logic signed [GW-1:0] C_ONE =
    {{(GW-FRACTIONAL_BITS-1){1'b0}}, 1'b1, {FRACTIONAL_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   output_q, output_d;

  logic signed [GW-1:0] w_level;
  logic signed [GW-1:0] w_target;
  logic signed [GW-1:0] w_attack, w_decay, w_release;
  logic signed [GW-1:0] w_sum, w_dec, w_rel;

  // Non-positive rates collapse to zero so the stage simply holds its level.
  function automatic logic signed [GW-1:0] clip_rate(input logic signed [TOTAL_BITS-1:0] r);
    if (!r[TOTAL_BITS-1] && (r != '0))
      return {1'b0, r};
    return '0;
  endfunction

  assign w_level   = {1'b0, output_q};
  assign w_target  = {{(GW-FRACTIONAL_BITS){1'b0}}, sustain, {(FRACTIONAL_BITS-AB){1'b0}}};
  assign w_attack  = clip_rate(attack_time);
  assign w_decay   = clip_rate(decay_time);
  assign w_release = clip_rate(release_time);

  // One guard bit above the level keeps these from wrapping before the clamps.
  assign w_sum = w_level + w_attack;
  assign w_dec = w_level - w_decay;
  assign w_rel = w_level - w_release;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      output_q <= '0;
    end else begin
      state_q  <= state_d;
      output_q <= output_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    output_d = output_q;
    case (state_q)
      S_IDLE: begin
        if (gate) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else if (w_sum >= C_ONE) begin
          output_d = C_ONE[TOTAL_BITS-1:0];
          state_d  = S_DECAY;
        end else begin
          output_d = w_sum[TOTAL_BITS-1:0];
        end
      end
      S_DECAY: begin
        if (!gate) begin
          state_d = S_RELEASE;
        end else if (w_dec <= w_target) begin
          output_d = w_target[TOTAL_BITS-1:0];
          state_d  = S_SUSTAIN;
        end else begin
          output_d = w_dec[TOTAL_BITS-1:0];
        end
      end
      S_SUSTAIN: begin
        if (!gate) state_d = S_RELEASE;
        else       output_d = w_target[TOTAL_BITS-1:0];
      end
      S_RELEASE: begin
        if (gate) begin
          state_d = S_ATTACK;
        end else if (w_rel[GW-1] || (w_rel == '0)) begin
          output_d = '0;
          state_d  = S_IDLE;
        end else begin
          output_d = w_rel[TOTAL_BITS-1:0];
        end
      end
      default: begin
        state_d  = S_IDLE;
        output_d = '0;
      end
    endcase
  end

  assign out    = (w_level >= C_ONE) ? '1 : output_q[FRACTIONAL_BITS-1 -: AB];
  assign active = reset & (gate | (state_q != S_IDLE));

endmodule

`default_nettype wire

// File: tb/tb_adsr.sv
// Bench for adsr: per-clock scoreboard against a behavioural envelope model,
// plus milestone checks for the full cycle, short times, retrigger and reset.
`default_nettype none

module tb_adsr;

  logic               clk;
  logic               reset;
  logic signed [47:0] attack_time, decay_time, release_time;
  logic [15:0]        sustain;
  logic               gate;
  logic [15:0]        dut_out;
  logic               dut_active;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0, M_ATTACK = 1, M_DECAY = 2, M_SUSTAIN = 3, M_RELEASE = 4;
  int     m_state;
  longint m_lvl;

  typedef struct {
    logic [15:0] out;
    logic        act;
  } exp_t;
  exp_t sb[$];

  adsr #(.TOTAL_BITS(48), .FRACTIONAL_BITS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .attack_time  (attack_time),
    .decay_time   (decay_time),
    .sustain      (sustain),
    .release_time (release_time),
    .gate         (gate),
    .out          (dut_out),
    .active       (dut_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Rate for a stage lasting the given number of clocks (fs = 1 clock).
  function automatic longint tv(input int clocks);
    return (longint'(1) << 32) / clocks;
  endfunction

  function automatic void model_step();
    longint one = longint'(1) << 32;
    longint a   = (attack_time  > 0) ? longint'(attack_time)  : 0;
    longint d   = (decay_time   > 0) ? longint'(decay_time)   : 0;
    longint r   = (release_time > 0) ? longint'(release_time) : 0;
    longint tgt = longint'(sustain) << 16;
    case (m_state)
      M_IDLE:    if (gate) m_state = M_ATTACK;
      M_ATTACK:  if (!gate) m_state = M_RELEASE;
                 else if (m_lvl + a >= one) begin m_lvl = one; m_state = M_DECAY; end
                 else m_lvl = m_lvl + a;
      M_DECAY:   if (!gate) m_state = M_RELEASE;
                 else if (m_lvl - d <= tgt) begin m_lvl = tgt; m_state = M_SUSTAIN; end
                 else m_lvl = m_lvl - d;
      M_SUSTAIN: if (!gate) m_state = M_RELEASE;
                 else m_lvl = tgt;
      default:   if (gate) m_state = M_ATTACK;
                 else if (m_lvl - r <= 0) begin m_lvl = 0; m_state = M_IDLE; end
                 else m_lvl = m_lvl - r;
    endcase
  endfunction

  function automatic logic [15:0] model_out();
    if (m_lvl >= (longint'(1) << 32)) return 16'hFFFF;
    return 16'((m_lvl >>> 16) & 64'hFFFF);
  endfunction

  task automatic tick();
    exp_t e;
    model_step();
    e.out = model_out();
    e.act = gate | (m_state != M_IDLE);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check_val("out", longint'(dut_out), longint'(e.out));
      check_val("active", longint'(dut_active), longint'(e.act));
    end
  endtask

  logic [15:0] prev;

  initial begin
    reset = 1'b0; gate = 1'b0; sustain = 16'h8000;
    attack_time = 48'(tv(100)); decay_time = 48'(tv(100)); release_time = 48'(tv(100));
    m_state = M_IDLE; m_lvl = 0;

    #12;
    check_val("rst_out", longint'(dut_out), 0);
    check_val("rst_active", longint'(dut_active), 0);
    reset = 1'b1;
    repeat (2) tick();
    check_val("idle_active", longint'(dut_active), 0);

    // Full attack/decay/sustain/release cycle, 0.1 s stages at fs = 1000.
    gate = 1'b1;
    tick();
    check_val("gate_active", longint'(dut_active), 1);
    repeat (101) tick();
    check_val("attack_top", longint'(dut_out), 16'hFFFF);
    repeat (100) tick();
    check_val("sustain_lvl", longint'(dut_out), 16'h8000);
    repeat (50) tick();
    gate = 1'b0;
    #1;
    check_val("rel_start", longint'(dut_out), 16'h8000);
    repeat (100) tick();
    check_val("rel_end_out", longint'(dut_out), 0);
    check_val("rel_end_act", longint'(dut_active), 0);

    // Short stage times.
    attack_time = 48'(tv(1)); decay_time = 48'(tv(5)); release_time = 48'(tv(5));
    gate = 1'b1;
    repeat (5) tick();
    gate = 1'b0;
    repeat (5) tick();
    check_val("short_out", longint'(dut_out), 0);
    check_val("short_act", longint'(dut_active), 0);

    // Non-positive attack rate holds the level forever.
    attack_time = -48'sd5;
    gate = 1'b1;
    repeat (20) tick();
    check_val("neg_rate_out", longint'(dut_out), 0);
    check_val("neg_rate_act", longint'(dut_active), 1);
    gate = 1'b0;
    repeat (3) tick();

    // Retrigger from the middle of release.
    attack_time = 48'(tv(100)); decay_time = 48'(tv(100)); release_time = 48'(tv(100));
    gate = 1'b1;
    repeat (160) tick();
    gate = 1'b0;
    repeat (20) tick();
    prev = dut_out;
    check_val("retrig_mid_nz", longint'(prev != 16'h0), 1);
    gate = 1'b1;
    tick();
    check_val("retrig_no_drop", longint'(dut_out >= prev), 1);
    repeat (5) tick();
    check_val("retrig_up", longint'(dut_out > prev), 1);

    // Asynchronous reset while decaying.
    repeat (80) tick();
    check_val("pre_rst_nz", longint'(dut_out != 16'h0), 1);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_out", longint'(dut_out), 0);
    check_val("async_rst_act", longint'(dut_active), 0);
    m_state = M_IDLE; m_lvl = 0;
    #1;
    reset = 1'b1;
    repeat (3) tick();
    gate = 1'b0;
    repeat (10) tick();

    check_val("sb_empty", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
